// File: rtl/sr_bank_driver.sv
// Drives a bank of SR flip-flops to a target word and verifies it through readback.
// Optional build macro SR_DRV_RETRY_EN enables bounded re-drive after a readback mismatch.
module sr_bank_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] set_q, set_d;
    logic [WIDTH-1:0] clr_q, clr_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic             err_q, err_d;
    logic             match;

`ifdef SR_DRV_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    logic [RW-1:0] retry_q, retry_d;
`endif

    assign match = (q_fb == target_q);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        set_d      = set_q;
        clr_d      = clr_q;
        err_d      = err_q;
        err_mask_d = err_mask_q;
`ifdef SR_DRV_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    target_d   = tgt_data;
                    set_d      = tgt_data & ~q_fb;
                    clr_d      = ~tgt_data & q_fb;
                    err_d      = 1'b0;
                    err_mask_d = '0;
`ifdef SR_DRV_RETRY_EN
                    retry_d    = '0;
`endif
                    // Nothing to set or clear exactly when the bank already holds the target.
                    state_d    = (tgt_data == q_fb) ? CHECK : DRIVE;
                end
            end
            DRIVE:  state_d = SETTLE;
            SETTLE: state_d = CHECK;
            CHECK: begin
                if (match) begin
                    state_d = IDLE;
                end else begin
`ifdef SR_DRV_RETRY_EN
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        set_d   = target_q & ~q_fb;
                        clr_d   = ~target_q & q_fb;
                        state_d = DRIVE;
                    end else begin
                        err_d      = 1'b1;
                        err_mask_d = q_fb ^ target_q;
                        state_d    = IDLE;
                    end
`else
                    err_d      = 1'b1;
                    err_mask_d = q_fb ^ target_q;
                    state_d    = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            set_q      <= '0;
            clr_q      <= '0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
`ifdef SR_DRV_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            set_q      <= set_d;
            clr_q      <= clr_d;
            err_q      <= err_d;
            err_mask_q <= err_mask_d;
`ifdef SR_DRV_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Commands decode from the state register so reset gates them off without a clock edge.
    assign s         = (state_q == DRIVE) ? set_q : '0;
    assign r         = (state_q == DRIVE) ? clr_q : '0;
    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == CHECK) && match;
    assign err       = err_q;
    assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Randomized self-checking bench for sr_bank_driver against a transaction-level model
// of the drive/verify/retry behaviour and a behavioural SR flip-flop bank.
module tb_sr_bank_driver;

    localparam int W  = 8;
    localparam int MR = 3;
`ifdef SR_DRV_RETRY_EN
    localparam int MAX_ATT = MR + 1;
`else
    localparam int MAX_ATT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         tgt_valid;
    logic [W-1:0] tgt_data;
    logic         tgt_ready;
    logic [W-1:0] q_fb;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] err_mask;

    logic [W-1:0] q_m   = '0;
    logic [W-1:0] stuck = '0;
    logic         exp_err;
    logic [W-1:0] exp_mask;
    int           total = 0;
    int           bad   = 0;

    sr_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .q_fb      (q_fb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_mask  (err_mask)
    );

    always #5 clk = ~clk;

    // Synchronous SR bank; stuck bits are forced low on every update.
    always @(posedge clk) q_m <= ((q_m & ~r) | s) & ~stuck;
    assign q_fb = q_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ready", tgt_ready, 1);
        chk("idle_done", done, 0);
        chk("idle_s", s, 0);
        chk("idle_r", r, 0);
        chk("idle_err", err, exp_err);
        chk("idle_mask", err_mask, exp_mask);
        tgt_valid = 1'b0;
        tgt_data  = 8'($urandom);
    endtask

    task automatic run_txn(input logic [W-1:0] t);
        logic [W-1:0] q;
        logic [W-1:0] sv[4];
        logic [W-1:0] rv[4];
        logic [W-1:0] es, er;
        int n, len;
        bit ok;
        @(negedge clk);
        chk("pre_ready", tgt_ready, 1);
        chk("pre_busy", busy, 0);
        chk("pre_err", err, exp_err);
        chk("pre_mask", err_mask, exp_mask);
        q  = q_m;
        n  = 0;
        ok = (q == t);
        for (int a = 0; a < MAX_ATT && !ok; a++) begin
            sv[a] = t & ~q;
            rv[a] = ~t & q;
            q     = ((q & ~rv[a]) | sv[a]) & ~stuck;
            n++;
            ok    = (q == t);
        end
        len = (n == 0) ? 1 : 3 * n;
        tgt_valid = 1'b1;
        tgt_data  = t;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            es = (n > 0 && (c % 3) == 1) ? sv[(c - 1) / 3] : '0;
            er = (n > 0 && (c % 3) == 1) ? rv[(c - 1) / 3] : '0;
            chk("s", s, es);
            chk("r", r, er);
            chk("s_and_r", s & r, 0);
            chk("busy", busy, 1);
            chk("ready", tgt_ready, 0);
            chk("done", done, (c == len) && ok);
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_data  = 8'($urandom);
        end
        exp_err  = !ok;
        exp_mask = ok ? '0 : (q ^ t);
    endtask

    task automatic reset_mid(input int at_cycle);
        logic [W-1:0] t;
        @(negedge clk);
        t         = ~q_m;
        tgt_valid = 1'b1;
        tgt_data  = t;
        for (int c = 1; c <= at_cycle; c++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
        end
        chk("rst_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mask", err_mask, 0);
        @(negedge clk);
        reset    = 1'b0;
        exp_err  = 1'b0;
        exp_mask = '0;
        @(negedge clk);
        chk("rel_ready", tgt_ready, 1);
        chk("rel_done", done, 0);
        chk("rel_busy", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = '0;
        exp_err   = 1'b0;
        exp_mask  = '0;
        repeat (2) @(negedge clk);
        chk("reset_s", s, 0);
        chk("reset_r", r, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_mask", err_mask, 0);
        reset = 1'b0;
        idle_cycle();

        run_txn(8'hA5);
        chk("bank_A5", q_m, 8'hA5);
        run_txn(8'hF0);
        run_txn(8'h3C);
        chk("bank_3C", q_m, 8'h3C);
        run_txn(8'h3C);
        chk("err_after_ok", err, 0);
        run_txn(8'h00);
        stuck = 8'h04;
        idle_cycle();
        run_txn(8'h04);
        chk("stuck_err_pred", exp_err, 1);
        idle_cycle();
        idle_cycle();
        chk("stuck_mask", err_mask, 8'h04);
        stuck = '0;
        idle_cycle();

        reset_mid(2);
        reset_mid(1);

        for (int i = 0; i < 1200; i++) begin
            if ((i % 16) == 0) begin
                stuck = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : '0;
                idle_cycle();
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
            case ($urandom_range(0, 3))
                0:       run_txn(q_m);
                default: run_txn(8'($urandom));
            endcase
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
